// File: rtl/idma_legalizer_r_axi_w_obi.sv
// rtl/idma_legalizer_r_axi_w_obi.sv - splits one 1D transfer into AXI read bursts and OBI word writes
module idma_legalizer_r_axi_w_obi #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32,
   parameter int LenWidth  = 32,
   parameter int MaxBeats  = 256,
   parameter int PageSize  = 4096,
   localparam int StrbWidth = DataWidth / 8,
   localparam int OffW      = $clog2(StrbWidth)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_src_addr_i,
   input  logic [AddrWidth-1:0] req_dst_addr_i,
   input  logic [LenWidth-1:0]  req_length_i,
   output logic                 ar_valid_o,
   input  logic                 ar_ready_i,
   output logic [AddrWidth-1:0] ar_addr_o,
   output logic [7:0]           ar_len_o,
   output logic [2:0]           ar_size_o,
   output logic                 r_dp_valid_o,
   input  logic                 r_dp_ready_i,
   output logic [OffW-1:0]      r_dp_offset_o,
   output logic [OffW-1:0]      r_dp_tailer_o,
   output logic [OffW-1:0]      r_dp_shift_o,
   output logic                 aw_valid_o,
   input  logic                 aw_ready_i,
   output logic [AddrWidth-1:0] aw_addr_o,
   output logic                 w_dp_valid_o,
   input  logic                 w_dp_ready_i,
   output logic [OffW-1:0]      w_dp_offset_o,
   output logic [OffW-1:0]      w_dp_tailer_o,
   output logic [OffW-1:0]      w_dp_shift_o,
   output logic                 busy_o
);
   localparam int RdBound = (PageSize < MaxBeats * StrbWidth) ? PageSize : MaxBeats * StrbWidth;
   localparam int RdOffW  = $clog2(RdBound);
   localparam int LW      = LenWidth + 1;

   typedef enum logic [0:0] {IDLE, BUSY} state_t;
   state_t state;

   logic [AddrWidth-1:0] rd_addr, wr_addr;
   logic [LW-1:0]        rd_rem, wr_rem;
   logic [OffW-1:0]      r_shift, w_shift;

   function automatic logic [LW-1:0] rd_bytes_f(input logic [RdOffW-1:0] lo, input logic [LW-1:0] rem);
      return (rem < (LW'(RdBound) - LW'(lo))) ? rem : (LW'(RdBound) - LW'(lo));
   endfunction

   function automatic logic [LW-1:0] wr_bytes_f(input logic [OffW-1:0] off, input logic [LW-1:0] rem);
      return (rem < (LW'(StrbWidth) - LW'(off))) ? rem : (LW'(StrbWidth) - LW'(off));
   endfunction

   function automatic logic [7:0] ar_len_f(input logic [OffW-1:0] off, input logic [LW-1:0] bytes);
      return 8'(((LW'(off) + bytes + LW'(StrbWidth - 1)) >> OffW) - LW'(1));
   endfunction

   // Invalid bytes after the chunk end within its last bus word.
   function automatic logic [OffW-1:0] tail_f(input logic [OffW-1:0] off, input logic [LW-1:0] bytes);
      return OffW'(LW'(0) - (LW'(off) + bytes));
   endfunction

   logic                 accept, rd_retire, wr_retire;
   logic [LW-1:0]        rd_bytes, wr_bytes, rd_rem_nx, wr_rem_nx, rd_rem_after, wr_rem_after;
   logic [AddrWidth-1:0] rd_addr_nx, wr_addr_nx, rd_ld_addr, wr_ld_addr;
   logic [LW-1:0]        rd_ld_rem, wr_ld_rem, rd_ld_bytes, wr_ld_bytes;
   logic [OffW-1:0]      rd_ld_shift, wr_ld_shift;

   always_comb begin
      accept    = (state == IDLE) && req_valid_i && (req_length_i != '0);
      rd_bytes  = rd_bytes_f(rd_addr[RdOffW-1:0], rd_rem);
      wr_bytes  = wr_bytes_f(wr_addr[OffW-1:0], wr_rem);
      rd_retire = (state == BUSY) && (rd_rem != '0) &&
                  (!ar_valid_o || ar_ready_i) && (!r_dp_valid_o || r_dp_ready_i);
      wr_retire = (state == BUSY) && (wr_rem != '0) &&
                  (!aw_valid_o || aw_ready_i) && (!w_dp_valid_o || w_dp_ready_i);
      rd_addr_nx   = rd_addr + AddrWidth'(rd_bytes);
      wr_addr_nx   = wr_addr + AddrWidth'(wr_bytes);
      rd_rem_nx    = rd_rem - rd_bytes;
      wr_rem_nx    = wr_rem - wr_bytes;
      rd_rem_after = rd_retire ? rd_rem_nx : rd_rem;
      wr_rem_after = wr_retire ? wr_rem_nx : wr_rem;
      // In IDLE the load path sources the request, in BUSY the advanced cursor.
      rd_ld_addr  = (state == IDLE) ? req_src_addr_i : rd_addr_nx;
      wr_ld_addr  = (state == IDLE) ? req_dst_addr_i : wr_addr_nx;
      rd_ld_rem   = (state == IDLE) ? LW'(req_length_i) : rd_rem_nx;
      wr_ld_rem   = (state == IDLE) ? LW'(req_length_i) : wr_rem_nx;
      rd_ld_shift = (state == IDLE) ? req_src_addr_i[OffW-1:0] : r_shift;
      wr_ld_shift = (state == IDLE) ? req_dst_addr_i[OffW-1:0] : w_shift;
      rd_ld_bytes = rd_bytes_f(rd_ld_addr[RdOffW-1:0], rd_ld_rem);
      wr_ld_bytes = wr_bytes_f(wr_ld_addr[OffW-1:0], wr_ld_rem);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         rd_addr       <= '0;
         wr_addr       <= '0;
         rd_rem        <= '0;
         wr_rem        <= '0;
         r_shift       <= '0;
         w_shift       <= '0;
         ar_valid_o    <= 1'b0;
         r_dp_valid_o  <= 1'b0;
         aw_valid_o    <= 1'b0;
         w_dp_valid_o  <= 1'b0;
         ar_addr_o     <= '0;
         ar_len_o      <= '0;
         r_dp_offset_o <= '0;
         r_dp_tailer_o <= '0;
         r_dp_shift_o  <= '0;
         aw_addr_o     <= '0;
         w_dp_offset_o <= '0;
         w_dp_tailer_o <= '0;
         w_dp_shift_o  <= '0;
      end else begin
         if (accept || rd_retire) begin
            rd_addr       <= rd_ld_addr;
            rd_rem        <= rd_ld_rem;
            r_shift       <= rd_ld_shift;
            ar_valid_o    <= (rd_ld_rem != '0);
            r_dp_valid_o  <= (rd_ld_rem != '0);
            ar_addr_o     <= rd_ld_addr;
            ar_len_o      <= ar_len_f(rd_ld_addr[OffW-1:0], rd_ld_bytes);
            r_dp_offset_o <= rd_ld_addr[OffW-1:0];
            r_dp_tailer_o <= tail_f(rd_ld_addr[OffW-1:0], rd_ld_bytes);
            r_dp_shift_o  <= rd_ld_shift;
         end else if (state == BUSY) begin
            if (ar_ready_i) ar_valid_o <= 1'b0;
            if (r_dp_ready_i) r_dp_valid_o <= 1'b0;
         end

         if (accept || wr_retire) begin
            wr_addr       <= wr_ld_addr;
            wr_rem        <= wr_ld_rem;
            w_shift       <= wr_ld_shift;
            aw_valid_o    <= (wr_ld_rem != '0);
            w_dp_valid_o  <= (wr_ld_rem != '0);
            aw_addr_o     <= {wr_ld_addr[AddrWidth-1:OffW], {OffW{1'b0}}};
            w_dp_offset_o <= wr_ld_addr[OffW-1:0];
            w_dp_tailer_o <= tail_f(wr_ld_addr[OffW-1:0], wr_ld_bytes);
            w_dp_shift_o  <= wr_ld_shift;
         end else if (state == BUSY) begin
            if (aw_ready_i) aw_valid_o <= 1'b0;
            if (w_dp_ready_i) w_dp_valid_o <= 1'b0;
         end

         if (accept) begin
            state <= BUSY;
         end else if ((state == BUSY) && (rd_rem_after == '0) && (wr_rem_after == '0)) begin
            state <= IDLE;
         end
      end
   end

   assign req_ready_o = (state == IDLE);
   assign busy_o      = (state == BUSY);
   assign ar_size_o   = 3'(OffW);

endmodule
